// File: rtl/perf_laten_stats_pkg.sv
// Shared constants and helpers for the latency statistics block: bucket
// initial values and a width-generic saturating adder.
`ifndef PANIC_DESC_TS_SIZE
`define PANIC_DESC_TS_SIZE 32
`endif

package panic_define;

    // Widest operand the saturating helper handles; callers truncate the result.
    localparam int SAT_W = 128;
    typedef logic [SAT_W-1:0] sat_t;

    // Empty-bucket values, sliced down to the timestamp width at the point of use.
    localparam sat_t MIN_INIT = '1;
    localparam sat_t MAX_INIT = '0;

    // a + b clamped to all-ones of width w (w < SAT_W); operands are zero-extended.
    function automatic sat_t sat_add(input sat_t a, input sat_t b, input int w);
        sat_t lim;
        sat_t s;
        lim = (sat_t'(1) << w) - sat_t'(1);
        s   = a + b;
        if (s > lim || s < a) begin
            return lim;
        end
        return s;
    endfunction

endpackage

// File: rtl/perf_laten_stats_bucket.sv
// One flow-class bucket: saturating latency sum and packet count plus the
// running min/max. Supports a global clear and a clear-then-update used by
// clear-on-read.
module perf_laten_bucket
    import panic_define::*;
#(
    parameter int TS_W  = 32,
    parameter int SUM_W = 64,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             rd_clr,
    input  logic             upd_valid,
    input  logic [TS_W-1:0]  upd_lat,
    output logic [SUM_W-1:0] bkt_sum,
    output logic [CNT_W-1:0] bkt_cnt,
    output logic [TS_W-1:0]  bkt_min,
    output logic [TS_W-1:0]  bkt_max
);

    logic [SUM_W-1:0] sum_q, sum_d, base_sum;
    logic [CNT_W-1:0] cnt_q, cnt_d, base_cnt;
    logic [TS_W-1:0]  min_q, min_d, base_min;
    logic [TS_W-1:0]  max_q, max_d, base_max;

    // Next bucket state: optional read-clear first, then the sample, global clear last.
    always_comb begin
        // NOTE: every variable gets a value before any branch so no latch is inferred.
        base_sum = rd_clr ? '0 : sum_q;
        base_cnt = rd_clr ? '0 : cnt_q;
        base_min = rd_clr ? MIN_INIT[TS_W-1:0] : min_q;
        base_max = rd_clr ? MAX_INIT[TS_W-1:0] : max_q;
        sum_d    = base_sum;
        cnt_d    = base_cnt;
        min_d    = base_min;
        max_d    = base_max;
        if (upd_valid) begin
            sum_d = SUM_W'(sat_add(sat_t'(base_sum), sat_t'(upd_lat), SUM_W));
            cnt_d = CNT_W'(sat_add(sat_t'(base_cnt), sat_t'(1), CNT_W));
            if (upd_lat < base_min) min_d = upd_lat;
            if (upd_lat > base_max) max_d = upd_lat;
        end
        if (clr) begin
            sum_d = '0;
            cnt_d = '0;
            min_d = MIN_INIT[TS_W-1:0];
            max_d = MAX_INIT[TS_W-1:0];
        end
    end

    // Bucket registers.
    always_ff @(posedge clk) begin
        // NOTE: the statistics are architectural state read by software, so they are
        // reset like any control flop rather than left as uninitialised storage.
        if (rst) begin
            sum_q <= '0;
            cnt_q <= '0;
            min_q <= MIN_INIT[TS_W-1:0];
            max_q <= MAX_INIT[TS_W-1:0];
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            sum_q <= sum_d;
            cnt_q <= cnt_d;
            min_q <= min_d;
            max_q <= max_d;
        end
    end

    assign bkt_sum = sum_q;
    assign bkt_cnt = cnt_q;
    assign bkt_min = min_q;
    assign bkt_max = max_q;

endmodule

// File: rtl/perf_laten_stats.sv
// Per-flow-class latency statistics. Stage 1 registers the sample latency,
// stage 2 updates the class bucket; reads return one cycle after the request
// and see bucket contents from before any same-cycle update.
`ifndef PANIC_DESC_TS_SIZE
`define PANIC_DESC_TS_SIZE 32
`endif

module perf_laten_stats
    import panic_define::*;
#(
    parameter int NUM_CLASS     = 8,
    parameter int CLASS_W       = ($clog2(NUM_CLASS) < 5) ? 5 : $clog2(NUM_CLASS),
    parameter int TS_W          = `PANIC_DESC_TS_SIZE,
    parameter int SUM_W         = 64,
    parameter int CNT_W         = 32,
    parameter int CLEAR_ON_READ = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               s_valid,
    input  logic [TS_W-1:0]    s_ts,
    input  logic [TS_W-1:0]    timestamp,
    input  logic [CLASS_W-1:0] s_class,
    input  logic               clr,
    input  logic               rd_req,
    input  logic [CLASS_W-1:0] rd_class,
    output logic               rd_valid,
    output logic               rd_err,
    output logic [SUM_W-1:0]   rd_sum,
    output logic [CNT_W-1:0]   rd_cnt,
    output logic [TS_W-1:0]    rd_min,
    output logic [TS_W-1:0]    rd_max,
    output logic [CNT_W-1:0]   drop_cnt
);

    // One extra bit so NUM_CLASS itself is representable when CLASS_W bits are exactly full.
    localparam logic [CLASS_W:0] NUM_CLASS_EXT = (CLASS_W+1)'(NUM_CLASS);

    function automatic logic in_range(input logic [CLASS_W-1:0] c);
        return {1'b0, c} < NUM_CLASS_EXT;
    endfunction

    // Stage 1: latency, class and valid.
    logic               s1_valid_q, s1_valid_d;
    logic [TS_W-1:0]    s1_lat_q, s1_lat_d;
    logic [CLASS_W-1:0] s1_class_q, s1_class_d;

    // Read port and drop counter.
    logic               rd_valid_q, rd_valid_d;
    logic               rd_err_q, rd_err_d;
    logic [SUM_W-1:0]   rd_sum_q, rd_sum_d;
    logic [CNT_W-1:0]   rd_cnt_q, rd_cnt_d;
    logic [TS_W-1:0]    rd_min_q, rd_min_d;
    logic [TS_W-1:0]    rd_max_q, rd_max_d;
    logic [CNT_W-1:0]   drop_cnt_q, drop_cnt_d;

    // Bucket outputs and the selected read class.
    logic [SUM_W-1:0]   bkt_sum [NUM_CLASS];
    logic [CNT_W-1:0]   bkt_cnt [NUM_CLASS];
    logic [TS_W-1:0]    bkt_min [NUM_CLASS];
    logic [TS_W-1:0]    bkt_max [NUM_CLASS];
    logic [SUM_W-1:0]   sel_sum;
    logic [CNT_W-1:0]   sel_cnt;
    logic [TS_W-1:0]    sel_min;
    logic [TS_W-1:0]    sel_max;

    // Stage 1: modular subtraction gives the right latency across a timestamp wrap.
    always_comb begin
        s1_valid_d = s_valid & ~clr;
        s1_lat_d   = timestamp - s_ts;
        s1_class_d = s_class;
    end

    // One bucket per class; stage 2 is the bucket's own update.
    for (genvar g = 0; g < NUM_CLASS; g++) begin : g_bucket
        perf_laten_bucket #(
            .TS_W  (TS_W),
            .SUM_W (SUM_W),
            .CNT_W (CNT_W)
        ) u_bucket (
            .clk       (clk),
            .rst       (rst),
            .clr       (clr),
            .rd_clr    ((CLEAR_ON_READ != 0) && rd_req && (rd_class == CLASS_W'(g))),
            .upd_valid (s1_valid_q && (s1_class_q == CLASS_W'(g))),
            .upd_lat   (s1_lat_q),
            .bkt_sum   (bkt_sum[g]),
            .bkt_cnt   (bkt_cnt[g]),
            .bkt_min   (bkt_min[g]),
            .bkt_max   (bkt_max[g])
        );
    end

    // Read mux; an out-of-range class falls through to the empty-bucket values.
    always_comb begin
        sel_sum = '0;
        sel_cnt = '0;
        sel_min = MIN_INIT[TS_W-1:0];
        sel_max = MAX_INIT[TS_W-1:0];
        for (int i = 0; i < NUM_CLASS; i++) begin
            if (rd_class == CLASS_W'(i)) begin
                sel_sum = bkt_sum[i];
                sel_cnt = bkt_cnt[i];
                sel_min = bkt_min[i];
                sel_max = bkt_max[i];
            end
        end
    end

    // Read response capture (data held between reads) and drop counting.
    always_comb begin
        rd_valid_d = rd_req;
        rd_err_d   = rd_req & ~in_range(rd_class);
        rd_sum_d   = rd_sum_q;
        rd_cnt_d   = rd_cnt_q;
        rd_min_d   = rd_min_q;
        rd_max_d   = rd_max_q;
        if (rd_req) begin
            rd_sum_d = sel_sum;
            rd_cnt_d = sel_cnt;
            rd_min_d = sel_min;
            rd_max_d = sel_max;
        end
        drop_cnt_d = drop_cnt_q;
        if (clr) begin
            drop_cnt_d = '0;
        end else if (s1_valid_q && !in_range(s1_class_q)) begin
            drop_cnt_d = CNT_W'(sat_add(sat_t'(drop_cnt_q), sat_t'(1), CNT_W));
        end
    end

    // Pipeline, read and drop registers; reset discards in-flight samples and reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_lat_q   <= '0;
            s1_class_q <= '0;
            rd_valid_q <= 1'b0;
            rd_err_q   <= 1'b0;
            rd_sum_q   <= '0;
            rd_cnt_q   <= '0;
            rd_min_q   <= MIN_INIT[TS_W-1:0];
            rd_max_q   <= MAX_INIT[TS_W-1:0];
            drop_cnt_q <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_lat_q   <= s1_lat_d;
            s1_class_q <= s1_class_d;
            rd_valid_q <= rd_valid_d;
            rd_err_q   <= rd_err_d;
            rd_sum_q   <= rd_sum_d;
            rd_cnt_q   <= rd_cnt_d;
            rd_min_q   <= rd_min_d;
            rd_max_q   <= rd_max_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign rd_valid = rd_valid_q;
    assign rd_err   = rd_err_q;
    assign rd_sum   = rd_sum_q;
    assign rd_cnt   = rd_cnt_q;
    assign rd_min   = rd_min_q;
    assign rd_max   = rd_max_q;
    assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_perf_laten_stats.sv
// Bench for perf_laten_stats: two instances (plain and clear-on-read) share
// stimulus; a behavioural model predicts every output every cycle, and
// directed scenarios pin the model with literal values.
module tb_perf_laten_stats;

    localparam int NC = 6;
    localparam int CW = 5;
    localparam int TW = 32;
    localparam int SW = 16;
    localparam int NW = 8;

    localparam longint SUM_MAX = (64'd1 << SW) - 1;
    localparam longint CNT_MAX = (64'd1 << NW) - 1;
    localparam longint MIN_E   = 64'hFFFF_FFFF;

    logic          clk = 1'b0;
    logic          rst;
    logic          s_valid;
    logic [TW-1:0] s_ts;
    logic [TW-1:0] timestamp;
    logic [CW-1:0] s_class;
    logic          clr;
    logic          rd_req;
    logic [CW-1:0] rd_class;

    logic          rd_valid [2];
    logic          rd_err   [2];
    logic [SW-1:0] rd_sum   [2];
    logic [NW-1:0] rd_cnt   [2];
    logic [TW-1:0] rd_min   [2];
    logic [TW-1:0] rd_max   [2];
    logic [NW-1:0] drop_cnt [2];

    perf_laten_stats #(
        .NUM_CLASS(NC), .CLASS_W(CW), .TS_W(TW), .SUM_W(SW), .CNT_W(NW), .CLEAR_ON_READ(0)
    ) dut0 (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ts(s_ts), .timestamp(timestamp),
        .s_class(s_class), .clr(clr), .rd_req(rd_req), .rd_class(rd_class),
        .rd_valid(rd_valid[0]), .rd_err(rd_err[0]), .rd_sum(rd_sum[0]), .rd_cnt(rd_cnt[0]),
        .rd_min(rd_min[0]), .rd_max(rd_max[0]), .drop_cnt(drop_cnt[0])
    );

    perf_laten_stats #(
        .NUM_CLASS(NC), .CLASS_W(CW), .TS_W(TW), .SUM_W(SW), .CNT_W(NW), .CLEAR_ON_READ(1)
    ) dut1 (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ts(s_ts), .timestamp(timestamp),
        .s_class(s_class), .clr(clr), .rd_req(rd_req), .rd_class(rd_class),
        .rd_valid(rd_valid[1]), .rd_err(rd_err[1]), .rd_sum(rd_sum[1]), .rd_cnt(rd_cnt[1]),
        .rd_min(rd_min[1]), .rd_max(rd_max[1]), .drop_cnt(drop_cnt[1])
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Bucket contents per instance (index 1 is the clear-on-read instance).
    longint m_sum [2][NC];
    longint m_cnt [2][NC];
    longint m_min [2][NC];
    longint m_max [2][NC];
    longint m_drop [2];
    // A sample accepted on one edge lands in its bucket on the next edge.
    bit     p_valid;
    longint p_lat;
    int     p_class;
    // Expected registered outputs.
    bit     e_valid [2];
    bit     e_err   [2];
    longint e_sum [2], e_cnt [2], e_min [2], e_max [2];

    task automatic empty_bucket(input int k, input int c);
        m_sum[k][c] = 0;
        m_cnt[k][c] = 0;
        m_min[k][c] = MIN_E;
        m_max[k][c] = 0;
    endtask

    task automatic model_edge();
        logic [TW-1:0] d;
        int rc;
        int sc;
        d  = timestamp - s_ts;
        rc = int'(rd_class);
        sc = int'(s_class);
        if (rst) begin
            for (int k = 0; k < 2; k++) begin
                for (int c = 0; c < NC; c++) empty_bucket(k, c);
                m_drop[k]  = 0;
                e_valid[k] = 1'b0;
                e_err[k]   = 1'b0;
                e_sum[k]   = 0;
                e_cnt[k]   = 0;
                e_min[k]   = MIN_E;
                e_max[k]   = 0;
            end
            p_valid = 1'b0;
            return;
        end
        // Reads observe the buckets as they stood before this edge.
        for (int k = 0; k < 2; k++) begin
            e_valid[k] = rd_req;
            e_err[k]   = rd_req && (rc >= NC);
            if (rd_req) begin
                if (rc >= NC) begin
                    e_sum[k] = 0; e_cnt[k] = 0; e_min[k] = MIN_E; e_max[k] = 0;
                end else begin
                    e_sum[k] = m_sum[k][rc]; e_cnt[k] = m_cnt[k][rc];
                    e_min[k] = m_min[k][rc]; e_max[k] = m_max[k][rc];
                end
            end
        end
        if (clr) begin
            for (int k = 0; k < 2; k++) begin
                for (int c = 0; c < NC; c++) empty_bucket(k, c);
                m_drop[k] = 0;
            end
            p_valid = 1'b0;
            return;
        end
        if (rd_req && rc < NC) empty_bucket(1, rc);
        if (p_valid) begin
            for (int k = 0; k < 2; k++) begin
                if (p_class >= NC) begin
                    m_drop[k] = (m_drop[k] + 1 > CNT_MAX) ? CNT_MAX : m_drop[k] + 1;
                end else begin
                    m_sum[k][p_class] = (m_sum[k][p_class] + p_lat > SUM_MAX) ? SUM_MAX
                                        : m_sum[k][p_class] + p_lat;
                    m_cnt[k][p_class] = (m_cnt[k][p_class] + 1 > CNT_MAX) ? CNT_MAX
                                        : m_cnt[k][p_class] + 1;
                    if (p_lat < m_min[k][p_class]) m_min[k][p_class] = p_lat;
                    if (p_lat > m_max[k][p_class]) m_max[k][p_class] = p_lat;
                end
            end
        end
        p_valid = s_valid;
        p_lat   = longint'(d);
        p_class = sc;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_edge();
        end
    end

    // Compare every output of both instances on every falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                for (int k = 0; k < 2; k++) begin
                    check($sformatf("rd_valid[%0d]", k), 64'(rd_valid[k]), 64'(e_valid[k]));
                    check($sformatf("rd_err[%0d]", k),   64'(rd_err[k]),   64'(e_err[k]));
                    check($sformatf("rd_sum[%0d]", k),   64'(rd_sum[k]),   e_sum[k]);
                    check($sformatf("rd_cnt[%0d]", k),   64'(rd_cnt[k]),   e_cnt[k]);
                    check($sformatf("rd_min[%0d]", k),   64'(rd_min[k]),   e_min[k]);
                    check($sformatf("rd_max[%0d]", k),   64'(rd_max[k]),   e_max[k]);
                    check($sformatf("drop_cnt[%0d]", k), 64'(drop_cnt[k]), m_drop[k]);
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_raw(input int c, input logic [TW-1:0] ts_in, input logic [TW-1:0] now);
        s_valid   = 1'b1;
        s_class   = CW'(c);
        s_ts      = ts_in;
        timestamp = now;
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic send(input int c, input logic [TW-1:0] lat);
        logic [TW-1:0] now;
        now = $urandom;
        send_raw(c, now - lat, now);
    endtask

    task automatic read(input int c);
        rd_req   = 1'b1;
        rd_class = CW'(c);
        @(negedge clk);
        rd_req = 1'b0;
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    // Literal expectation for a completed read on instance k.
    task automatic expect_rd(input int k, input string tag, input longint sum, input longint cnt,
                             input longint mn, input longint mx, input bit err);
        check($sformatf("%s valid[%0d]", tag, k), 64'(rd_valid[k]), 64'd1);
        check($sformatf("%s err[%0d]", tag, k),   64'(rd_err[k]),   64'(err));
        check($sformatf("%s sum[%0d]", tag, k),   64'(rd_sum[k]),   sum);
        check($sformatf("%s cnt[%0d]", tag, k),   64'(rd_cnt[k]),   cnt);
        check($sformatf("%s min[%0d]", tag, k),   64'(rd_min[k]),   mn);
        check($sformatf("%s max[%0d]", tag, k),   64'(rd_max[k]),   mx);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [TW-1:0] lat;
        rst = 1'b1; s_valid = 1'b0; s_ts = '0; timestamp = '0; s_class = '0;
        clr = 1'b0; rd_req = 1'b0; rd_class = '0;
        idle(3);
        rst    = 1'b0;
        chk_en = 1'b1;

        // Reset state.
        for (int k = 0; k < 2; k++) begin
            check("reset valid", 64'(rd_valid[k]), 64'd0);
            check("reset min",   64'(rd_min[k]),   64'hFFFF_FFFF);
            check("reset max",   64'(rd_max[k]),   64'd0);
            check("reset drop",  64'(drop_cnt[k]), 64'd0);
        end

        // Three back-to-back samples to one class, read two cycles after the last.
        pulse_clr();
        send(3, 10); send(3, 20); send(3, 30);
        idle(1);
        read(3);
        for (int k = 0; k < 2; k++) expect_rd(k, "burst", 60, 3, 10, 30, 1'b0);
        idle(1);
        check("hold valid", 64'(rd_valid[0]), 64'd0);
        check("hold sum",   64'(rd_sum[0]),   64'd60);

        // Timestamp wrap.
        send_raw(1, 32'hFFFF_FFF0, 32'h0000_0010);
        idle(1);
        read(1);
        expect_rd(0, "wrap", 32, 1, 32, 32, 1'b0);

        // Out-of-range class: dropped, counted, buckets untouched.
        send(NC, 5);
        idle(1);
        for (int k = 0; k < 2; k++) check("drop one", 64'(drop_cnt[k]), 64'd1);
        read(NC);
        for (int k = 0; k < 2; k++) expect_rd(k, "bad class", 0, 0, MIN_E, 0, 1'b1);
        read(1);
        expect_rd(0, "unchanged", 32, 1, 32, 32, 1'b0);

        // Read colliding with a stage-2 update of the same class.
        send(2, 50);
        idle(1);
        send(2, 7);
        read(2);
        for (int k = 0; k < 2; k++) expect_rd(k, "collide old", 50, 1, 50, 50, 1'b0);
        read(2);
        expect_rd(0, "collide new", 57, 2, 7, 50, 1'b0);
        expect_rd(1, "collide new", 7, 1, 7, 7, 1'b0);

        // Sum saturation, then clr against a same-cycle update.
        pulse_clr();
        send(4, 65530); send(4, 100);
        idle(1);
        read(4);
        for (int k = 0; k < 2; k++) expect_rd(k, "sat", SUM_MAX, 2, 100, 65530, 1'b0);
        send(4, 5);
        pulse_clr();
        idle(1);
        read(4);
        for (int k = 0; k < 2; k++) expect_rd(k, "clr wins", 0, 0, MIN_E, 0, 1'b0);

        // Mid-operation reset drops the in-flight sample; the next one counts.
        send(0, 9);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        send(0, 4);
        idle(1);
        read(0);
        for (int k = 0; k < 2; k++) expect_rd(k, "post rst", 4, 1, 4, 4, 1'b0);

        // Randomised traffic: a long clr-free phase on two classes drives the
        // counters into saturation, then mixed traffic with clr and rst.
        for (int i = 0; i < 4000; i++) begin
            s_valid = ($urandom_range(0, 9) < 7);
            if (i < 2000) begin
                s_class = ($urandom_range(0, 2) == 0) ? CW'($urandom_range(NC, 31))
                                                      : CW'($urandom_range(0, 1));
            end else begin
                s_class = ($urandom_range(0, 7) == 0) ? CW'($urandom_range(NC, 31))
                                                      : CW'($urandom_range(0, NC - 1));
            end
            lat       = ($urandom_range(0, 19) == 0) ? $urandom : $urandom_range(0, 400);
            timestamp = $urandom;
            s_ts      = timestamp - lat;
            rd_req    = ($urandom_range(0, 1) == 1);
            rd_class  = ($urandom_range(0, 7) == 0) ? CW'($urandom_range(NC, 31))
                                                    : CW'($urandom_range(0, NC - 1));
            clr       = (i >= 2000) && ($urandom_range(0, 149) == 0);
            rst       = (i >= 2000) && ($urandom_range(0, 399) == 0);
            @(negedge clk);
        end
        s_valid = 1'b0; rd_req = 1'b0; clr = 1'b0; rst = 1'b0;
        idle(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
